scpu_ctrl: RTL and testbench

//  Main control decoder of the single-cycle MIPS CPU. Decodes instruction OPcode/Fun into

---
 rtl/scpu_ctrl.sv | 151 +++++++++++++++
 tb/tb_scpu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scpu_ctrl.sv
// Main control decoder of the single-cycle MIPS CPU.
//
// Decodes the instruction opcode (and funct field for R-type) into datapath
// controls. Decode is purely combinational. The only state is a sticky
// illegal-instruction flag kept for debug visibility.
//
// Ports:
//   clk         - rising-edge clock, only clocks the illegal flag
//   rst_n       - asynchronous active-low reset
//   OPcode      - instr[31:26]
//   Fun         - instr[5:0], only meaningful when OPcode is R-type
//   MIO_ready   - memory/IO ready; reserved, ignored
//   RegDst      - write register is rd (1) or rt (0)
//   ALUSrc_B    - ALU operand B is the sign-extended immediate
//   MemtoReg    - write-back data comes from memory
//   RegWrite    - register-file write enable
//   mem_w       - data-memory write enable
//   Branch      - beq
//   Jump        - j
//   ALU_Control - 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
//   CPU_MIO     - current instruction accesses memory/IO (lw/sw)
//   illegal     - sticky: an undecodable instruction has been sampled
module scpu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  output logic       RegDst,
  output logic       ALUSrc_B,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       mem_w,
  output logic       Branch,
  output logic       Jump,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic       illegal
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FunSrl = 6'h02;
  localparam logic [5:0] FunAdd = 6'h20;
  localparam logic [5:0] FunSub = 6'h22;
  localparam logic [5:0] FunAnd = 6'h24;
  localparam logic [5:0] FunOr  = 6'h25;
  localparam logic [5:0] FunXor = 6'h26;
  localparam logic [5:0] FunNor = 6'h27;
  localparam logic [5:0] FunSlt = 6'h2a;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  logic instr_illegal;
  logic illegal_q;

  // Ready is reserved for a future multi-cycle memory interface.
  logic unused_mio_ready;
  assign unused_mio_ready = MIO_ready;

  always_comb begin
    // Safe defaults: nothing writes, nothing redirects the PC.
    RegDst        = 1'b0;
    ALUSrc_B      = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    mem_w         = 1'b0;
    Branch        = 1'b0;
    Jump          = 1'b0;
    ALU_Control   = AluAdd;
    CPU_MIO       = 1'b0;
    instr_illegal = 1'b0;

    case (OPcode)
      OpRtype: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        case (Fun)
          FunAdd:  ALU_Control = AluAdd;
          FunSub:  ALU_Control = AluSub;
          FunAnd:  ALU_Control = AluAnd;
          FunOr:   ALU_Control = AluOr;
          FunXor:  ALU_Control = AluXor;
          FunNor:  ALU_Control = AluNor;
          FunSlt:  ALU_Control = AluSlt;
          FunSrl:  ALU_Control = AluSrl;
          default: begin
            // Unknown funct must not write the register file.
            RegDst        = 1'b0;
            RegWrite      = 1'b0;
            instr_illegal = 1'b1;
          end
        endcase
      end
      OpLw: begin
        ALUSrc_B = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        CPU_MIO  = 1'b1;
      end
      OpSw: begin
        ALUSrc_B = 1'b1;
        mem_w    = 1'b1;
        CPU_MIO  = 1'b1;
      end
      OpBeq: begin
        Branch      = 1'b1;
        ALU_Control = AluSub;
      end
      OpJ: begin
        Jump = 1'b1;
      end
      OpAddi: begin
        ALUSrc_B = 1'b1;
        RegWrite = 1'b1;
      end
      OpSlti: begin
        ALUSrc_B    = 1'b1;
        RegWrite    = 1'b1;
        ALU_Control = AluSlt;
      end
      default: begin
        instr_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (instr_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_scpu_ctrl.sv
// Self-checking bench for scpu_ctrl: table-driven reference decoder plus a
// sticky-flag model, checked every cycle, with hand-written literal checks.
module tb_scpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OPcode = 6'h3f;
  logic [5:0] Fun = 6'h00;
  logic       MIO_ready = 1'b0;
  logic       RegDst, ALUSrc_B, MemtoReg, RegWrite, mem_w, Branch, Jump, CPU_MIO, illegal;
  logic [2:0] ALU_Control;

  int checks = 0;
  int errors = 0;

  scpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OPcode      (OPcode),
    .Fun         (Fun),
    .MIO_ready   (MIO_ready),
    .RegDst      (RegDst),
    .ALUSrc_B    (ALUSrc_B),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .mem_w       (mem_w),
    .Branch      (Branch),
    .Jump        (Jump),
    .ALU_Control (ALU_Control),
    .CPU_MIO     (CPU_MIO),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Packed as {RegDst, ALUSrc_B, MemtoReg, RegWrite, mem_w, Branch, Jump, CPU_MIO, ALU[2:0]}
  logic [10:0] act_ctl;
  assign act_ctl = {RegDst, ALUSrc_B, MemtoReg, RegWrite, mem_w, Branch, Jump, CPU_MIO,
                    ALU_Control};

  function automatic logic [10:0] mk(input bit rd, input bit as, input bit mr, input bit rw,
                                     input bit mw, input bit br, input bit j, input bit mio,
                                     input logic [2:0] alu);
    return {rd, as, mr, rw, mw, br, j, mio, alu};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fun;
    bit          use_fun;
    logic [10:0] ctl;
  } ent_t;

  ent_t tbl[14];

  function automatic void build_table();
    logic [5:0] funs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
    logic [2:0] alus [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b101};
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{op: 6'h00, fun: funs[i], use_fun: 1'b1, ctl: mk(1, 0, 0, 1, 0, 0, 0, 0, alus[i])};
    end
    tbl[8]  = '{op: 6'h23, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 1, 1, 1, 0, 0, 0, 1, 3'b010)};
    tbl[9]  = '{op: 6'h2b, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 1, 0, 0, 1, 0, 0, 1, 3'b010)};
    tbl[10] = '{op: 6'h04, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b110)};
    tbl[11] = '{op: 6'h02, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b010)};
    tbl[12] = '{op: 6'h08, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b010)};
    tbl[13] = '{op: 6'h0a, fun: 6'h0, use_fun: 1'b0, ctl: mk(0, 1, 0, 1, 0, 0, 0, 0, 3'b111)};
  endfunction

  // Anything not found in the table is illegal and decodes to all-zero with add.
  function automatic void lookup(input logic [5:0] op, input logic [5:0] fun,
                                 output logic [10:0] ctl, output bit bad);
    ctl = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    bad = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].op == op && (!tbl[i].use_fun || tbl[i].fun == fun)) begin
        ctl = tbl[i].ctl;
        bad = 1'b0;
      end
    end
  endfunction

  // Sticky flag model.
  bit exp_ill = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    logic [10:0] c;
    bit b;
    if (!rst_n) begin
      exp_ill = 1'b0;
    end else begin
      lookup(OPcode, Fun, c, b);
      if (b) exp_ill = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [10:0] c;
    bit b;
    lookup(OPcode, Fun, c, b);
    checks++;
    if (act_ctl !== c || illegal !== exp_ill) begin
      errors++;
      $display("FAIL model_cmp t=%0t op=%h fun=%h mio=%b ctl=%b want %b illegal=%b want %b",
               $time, OPcode, Fun, MIO_ready, act_ctl, c, illegal, exp_ill);
    end
  end

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fun);
    @(posedge clk);
    #2;
    OPcode = op;
    Fun    = fun;
  endtask

  initial begin
    logic [5:0] rfun [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
    logic [2:0] ralu [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b101};
    logic [5:0] legal_ops [7] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0a, 6'h23, 6'h2b};
    build_table();

    // Reset holds the flag low despite an illegal opcode; first edge after release sets it.
    @(negedge clk);
    chk("reset_illegal", {10'b0, illegal}, 11'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("pre_edge_illegal", {10'b0, illegal}, 11'd0);
    @(negedge clk);
    chk("post_edge_illegal", {10'b0, illegal}, 11'd1);

    // R-type sweep with hand-written expectations.
    for (int i = 0; i < 8; i++) begin
      drive(6'h00, rfun[i]);
      @(negedge clk);
      chk($sformatf("rtype_fun_%h", rfun[i]), act_ctl, {8'b1001_0000, ralu[i]});
    end
    drive(6'h00, 6'h16);
    @(negedge clk);
    chk("rtype_bad_16", act_ctl, 11'b0000_0000_010);
    drive(6'h00, 6'h3f);
    @(negedge clk);
    chk("rtype_bad_3f", act_ctl, 11'b0000_0000_010);
    drive(6'h23, 6'h15);
    @(negedge clk);
    chk("lw", act_ctl, 11'b0111_0001_010);
    drive(6'h2b, 6'h00);
    @(negedge clk);
    chk("sw", act_ctl, 11'b0100_1001_010);
    drive(6'h04, 6'h2a);
    @(negedge clk);
    chk("beq", act_ctl, 11'b0000_0100_110);
    drive(6'h02, 6'h00);
    @(negedge clk);
    chk("j", act_ctl, 11'b0000_0010_010);
    drive(6'h24, 6'h20);
    @(negedge clk);
    chk("op_24", act_ctl, 11'b0000_0000_010);

    // MIO_ready toggling under each legal opcode; the model ignores it.
    for (int i = 0; i < 7; i++) begin
      drive(legal_ops[i], 6'h20);
      for (int k = 0; k < 2; k++) begin
        @(posedge clk);
        #2 MIO_ready = ~MIO_ready;
      end
    end
    @(negedge clk);
    chk("illegal_stays", {10'b0, illegal}, 11'd1);

    // Randomized: mostly legal encodings, with occasional full-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 2) == 0) ? 6'($urandom) : rfun[$urandom_range(0, 7)];
      @(posedge clk);
      #2;
      OPcode    = op;
      Fun       = fn;
      MIO_ready = 1'($urandom);
      rst_n     = ($urandom_range(0, 19) != 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
